// File: rtl/rsa_pkg.sv
// rsa_pkg: shared RSA constants, decrypt FSM states and the decrypt latency formula.
package rsa_pkg;

    localparam int RSA_W     = 6;
    localparam int RSA_AW    = 3;
    localparam int RSA_N     = 33;
    localparam int RSA_D     = 3;
    localparam int RSA_E     = 7;
    localparam int RSA_EXP_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SQR,
        S_MUL,
        S_RANGE,
        S_DONE
    } state_e;

    // Cycles from the accepting edge to d_d for a full exponentiation.
    function automatic int rsa_latency(input int w, input int exp_w, input int d);
        int ones;
        ones = 0;
        for (int i = 0; i < exp_w; i++) ones += (d >> i) & 1;
        return 2 + (w + 1) * (exp_w + ones);
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// rsa_modmul: interleaved shift-add modular multiplier, one start cycle plus W iterations.
module rsa_modmul #(
    parameter int W = 6,
    parameter int N = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W+1:0] NX = (W + 2)'(N);

    logic [W+1:0] acc_q, acc_d, t, t1, t2;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d;

    // Both operands stay below N, so two conditional subtractions restore acc < N.
    always_comb begin
        t      = {acc_q[W:0], 1'b0} + (a_q[W-1] ? {2'b00, b_q} : '0);
        t1     = (t >= NX) ? t - NX : t;
        t2     = (t1 >= NX) ? t1 - NX : t1;
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            acc_d  = '0;
            a_d    = a;
            b_d    = b;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d  = t2;
            a_d    = a_q << 1;
            cnt_d  = cnt_q - 1'b1;
            busy_d = cnt_q != CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && cnt_q == CW'(1);
    assign p    = t2[W-1:0];

endmodule

// File: rtl/rsa_decrypt_core.sv
// rsa_decrypt_core: buffered RSA decryption pt = ct^D mod N by left-to-right square-and-multiply.
// RSA_DEC_RANGE_CHECK_EN: reject ct >= N with err instead of reducing it once.
module rsa_decrypt_core
    import rsa_pkg::*;
#(
    parameter int W     = RSA_W,
    parameter int AW    = RSA_AW,
    parameter int N     = RSA_N,
    parameter int D     = RSA_D,
    parameter int EXP_W = RSA_EXP_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ct_wren,
    input  logic [AW-1:0] ct_wraddr,
    input  logic [W-1:0]  ct_in,
    input  logic          ds,
    input  logic [AW-1:0] rdaddr1,
    output logic [W-1:0]  pt_org,
    output logic          d_d,
    output logic          busy,
    output logic          err
);

    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [W-1:0] N_W = W'(N);
    localparam logic [EXP_W-1:0] D_B = EXP_W'(D);

    state_e state_q, state_d;
    logic [W-1:0] buf_q [2**AW];
    logic [W-1:0] buf_d [2**AW];
    logic [AW-1:0] addr_q, addr_d;
    logic [W-1:0] c_q, c_d, res_q, res_d, pt_q, pt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic mm_start, mm_busy, mm_done;
    logic [W-1:0] mm_b, mm_p;
`ifdef RSA_DEC_RANGE_CHECK_EN
    logic err_q, err_d;
`endif

    rsa_modmul #(.W(W), .N(N)) u_mm (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (res_q),
        .b     (mm_b),
        .busy  (mm_busy),
        .done  (mm_done),
        .p     (mm_p)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        addr_d   = addr_q;
        c_d      = c_q;
        res_d    = res_q;
        idx_d    = idx_q;
        pt_d     = pt_q;
        mm_start = 1'b0;
        mm_b     = (state_q == S_MUL) ? c_q : res_q;
`ifdef RSA_DEC_RANGE_CHECK_EN
        err_d    = 1'b0;
`endif
        if (ct_wren) buf_d[ct_wraddr] = ct_in;
        case (state_q)
            S_IDLE: begin
                if (ds) begin
                    state_d = S_LOAD;
                    addr_d  = rdaddr1;
                end
            end
            S_LOAD: begin
                c_d     = buf_q[addr_q];
                res_d   = W'(1);
                idx_d   = IW'(EXP_W - 1);
                state_d = S_CHECK;
            end
            S_CHECK: begin
`ifdef RSA_DEC_RANGE_CHECK_EN
                state_d = (c_q >= N_W) ? S_RANGE : S_SQR;
`else
                c_d     = (c_q >= N_W) ? c_q - N_W : c_q;
                state_d = S_SQR;
`endif
            end
`ifdef RSA_DEC_RANGE_CHECK_EN
            S_RANGE: begin
                pt_d    = '0;
                err_d   = 1'b1;
                state_d = S_DONE;
            end
`endif
            S_SQR, S_MUL: begin
                // The multiplier is idle only in the first cycle of each operation.
                mm_start = !mm_busy;
                if (mm_done) begin
                    res_d = mm_p;
                    if (state_q == S_SQR && D_B[idx_q]) begin
                        state_d = S_MUL;
                    end else begin
                        state_d = (idx_q == '0) ? S_DONE : S_SQR;
                        pt_d    = (idx_q == '0) ? mm_p : pt_q;
                        idx_d   = idx_q - 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= '{default: '0};
            addr_q  <= '0;
            c_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            pt_q    <= '0;
`ifdef RSA_DEC_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            c_q     <= c_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            pt_q    <= pt_d;
`ifdef RSA_DEC_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign pt_org = pt_q;
    assign d_d    = state_q == S_DONE;
    assign busy   = state_q != S_IDLE;
`ifdef RSA_DEC_RANGE_CHECK_EN
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// tb_rsa_decrypt_core: scoreboard bench checking rsa_decrypt_core against a plain modular-power model.
module tb_rsa_decrypt_core;
    import rsa_pkg::*;

    logic clk = 0, rst = 1;
    logic ct_wren = 0, ds = 0;
    logic [RSA_AW-1:0] ct_wraddr = 0, rdaddr1 = 0;
    logic [RSA_W-1:0] ct_in = 0;
    logic [RSA_W-1:0] pt_org;
    logic d_d, busy, err;

    typedef struct {
        int pt;
        int er;
        int lat;
    } exp_t;

    exp_t sb[$];
    int mem[2**RSA_AW];
    int n_tests = 0, n_fail = 0, n_done = 0, cyc = 0, acc_cyc = 0;

    rsa_decrypt_core dut (
        .clk       (clk),
        .rst       (rst),
        .ct_wren   (ct_wren),
        .ct_wraddr (ct_wraddr),
        .ct_in     (ct_in),
        .ds        (ds),
        .rdaddr1   (rdaddr1),
        .pt_org    (pt_org),
        .d_d       (d_d),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic exp_t model(input int ct);
        exp_t e;
        int c, r;
        c = ct;
        e.er  = 0;
        e.lat = rsa_latency(RSA_W, RSA_EXP_W, RSA_D);
`ifdef RSA_DEC_RANGE_CHECK_EN
        if (c >= RSA_N) begin
            e.pt  = 0;
            e.er  = 1;
            e.lat = 3;
            return e;
        end
`else
        if (c >= RSA_N) c -= RSA_N;
`endif
        r = 1;
        for (int k = 0; k < RSA_D; k++) r = (r * c) % RSA_N;
        e.pt = r;
        return e;
    endfunction

    always @(negedge clk) begin
        if (d_d) begin
            n_done++;
            chk("queue_nonempty_at_dd", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("pt_org", int'(pt_org), e.pt);
                chk("err_at_dd", int'(err), e.er);
                chk("latency", cyc - acc_cyc, e.lat);
                chk("busy_at_dd", int'(busy), 1);
            end
        end else if (err) begin
            chk("err_without_dd", int'(err), 0);
        end
    end

    task automatic wr(input int addr, input int data);
        @(negedge clk);
        ct_wren = 1; ct_wraddr = addr[RSA_AW-1:0]; ct_in = data[RSA_W-1:0];
        @(negedge clk);
        ct_wren = 0;
        mem[addr] = data;
    endtask

    task automatic launch(input int addr);
        sb.push_back(model(mem[addr]));
        @(negedge clk);
        ds = 1; rdaddr1 = addr[RSA_AW-1:0];
        @(negedge clk);
        ds = 0;
        acc_cyc = cyc;
        chk("busy_after_accept", int'(busy), 1);
    endtask

    task automatic wait_done();
        int n0;
        bit got;
        n0 = n_done;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            got = n_done != n0;
        end
        chk("done_before_timeout", int'(got), 1);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic run(input int addr);
        launch(addr);
        wait_done();
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 2**RSA_AW; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset_pt", int'(pt_org), 0);
        chk("reset_dd", int'(d_d), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);

        wr(0, 14); run(0);
        wr(7, 31); run(7);
        wr(1, 0);  run(1);
        wr(2, 1);  run(2);
        wr(3, 40); run(3);
        wr(4, 63); run(4);
        wr(5, 33); run(5);

        // Disturb a run: re-issue ds and overwrite the active entry.
        wr(0, 14);
        launch(0);
        repeat (10) @(negedge clk);
        ds = 1; rdaddr1 = 5; ct_wren = 1; ct_wraddr = 0; ct_in = 50;
        @(negedge clk);
        ds = 0; ct_wren = 0;
        mem[0] = 50;
        n0 = n_done;
        wait_done();
        repeat (60) @(negedge clk);
        chk("single_dd", n_done - n0, 1);
        run(0);

        for (int t = 0; t < 20; t++) begin
            int a;
            a = $urandom_range(0, 2**RSA_AW - 1);
            wr(a, $urandom_range(0, 2**RSA_W - 1));
            run(a);
        end

        // Asynchronous reset in the middle of an operation.
        wr(6, 31);
        launch(6);
        repeat (20) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("rst_pt", int'(pt_org), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dd", int'(d_d), 0);
        chk("rst_err", int'(err), 0);
        sb.delete();
        for (int i = 0; i < 2**RSA_AW; i++) mem[i] = 0;
        n0 = n_done;
        @(negedge clk);
        rst = 0;
        repeat (60) @(negedge clk);
        chk("no_dd_after_rst", n_done - n0, 0);
        run(6);
        wr(6, 31); run(6);

        chk("queue_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
